// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: state codes, mux
// select codes, grant bookkeeping type and the strobe decode helper.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_SERVE_I = 2'd1;
    localparam logic [1:0] ARB_SERVE_D = 2'd2;

    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    typedef enum logic {
        WIN_I = 1'b0,
        WIN_D = 1'b1
    } winner_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic sel;
    } mem_cmd_t;

    // Strobes are a pure function of the state being entered and the captured
    // store flag, so the top can register them straight from the next-state.
    function automatic mem_cmd_t cmd_for_state(input logic [1:0] state, input logic is_write);
        mem_cmd_t cmd;
        cmd = '{rd: 1'b0, wr: 1'b0, sel: SEL_INSTR};
        case (state)
            ARB_SERVE_I: cmd = '{rd: 1'b1, wr: 1'b0, sel: SEL_INSTR};
            ARB_SERVE_D: cmd = '{rd: ~is_write, wr: is_write, sel: SEL_DATA};
            default:     cmd = '{rd: 1'b0, wr: 1'b0, sel: SEL_INSTR};
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Service watchdog: counts SERVE cycles without a memory answer and raises a
// sticky flag once the count reaches TIMEOUT_CYCLES.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic timeout_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 flag_reg;
    logic                 flag_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // TIMEOUT_CYCLES >= 2, so a cleared count can never raise the flag.
    assign flag_next = flag_reg | (count_next == TIMEOUT_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            flag_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            flag_reg  <= flag_next;
        end
    end

    assign timeout_err = flag_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data
// access, alternating under contention and stalling the waiting side.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_read,
    input  logic d_read,
    input  logic d_write,
    input  logic mem_ready,
    output logic mem_read,
    output logic mem_write,
    output logic addr_select,
    output logic i_busywait,
    output logic d_busywait,
    output logic timeout_err
);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    winner_t    last_winner_reg;
    winner_t    last_winner_next;
    logic       wr_reg;
    logic       wr_next;
    mem_cmd_t   cmd_reg;
    mem_cmd_t   cmd_next;
    logic       d_req;
    logic       wd_clear;
    logic       wd_inc;

    // A combined read+write request is a store.
    assign d_req = d_read | d_write;

    always_comb begin
        state_next       = state_reg;
        last_winner_next = last_winner_reg;
        wr_next          = wr_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (i_read && d_req) begin
                    if (last_winner_reg == WIN_D) begin
                        state_next = ARB_SERVE_I;
                    end else begin
                        state_next = ARB_SERVE_D;
                        wr_next    = d_write;
                    end
                end else if (i_read) begin
                    state_next = ARB_SERVE_I;
                end else if (d_req) begin
                    state_next = ARB_SERVE_D;
                    wr_next    = d_write;
                end
            end
            ARB_SERVE_I: begin
                // A dropped request is a flush: abandon without crediting the win.
                if (!i_read) begin
                    state_next = ARB_IDLE;
                end else if (mem_ready) begin
                    last_winner_next = WIN_I;
                    if (d_req) begin
                        state_next = ARB_SERVE_D;
                        wr_next    = d_write;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            ARB_SERVE_D: begin
                if (!d_req) begin
                    state_next = ARB_IDLE;
                end else if (mem_ready) begin
                    last_winner_next = WIN_D;
                    state_next       = i_read ? ARB_SERVE_I : ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    assign cmd_next = cmd_for_state(state_next, wr_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ARB_IDLE;
            last_winner_reg <= WIN_D;
            wr_reg          <= 1'b0;
            cmd_reg         <= '{rd: 1'b0, wr: 1'b0, sel: SEL_INSTR};
        end else begin
            state_reg       <= state_next;
            last_winner_reg <= last_winner_next;
            wr_reg          <= wr_next;
            cmd_reg         <= cmd_next;
        end
    end

    assign mem_read    = cmd_reg.rd;
    assign mem_write   = cmd_reg.wr;
    assign addr_select = cmd_reg.sel;

    assign i_busywait = i_read & ~((state_reg == ARB_SERVE_I) & mem_ready);
    assign d_busywait = d_req  & ~((state_reg == ARB_SERVE_D) & mem_ready);

    // Entering any SERVE state (including I->D hand-over) restarts the watchdog.
    assign wd_clear = (state_next != ARB_IDLE) && (state_next != state_reg);
    assign wd_inc   = (state_reg != ARB_IDLE) && !mem_ready;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_watchdog (
        .clk        (clk),
        .rst        (reset),
        .clear      (wd_clear),
        .inc        (wd_inc),
        .timeout_err(timeout_err)
    );

endmodule
